count_down: RTL and testbench

//  Loadable down-counter FSM, the decrementing counterpart of the team's 0..10 up-counter.

---
 rtl/count_pkg.sv | 15 +
 rtl/count_dn_core.sv | 45 ++++
 rtl/count_down.sv | 100 ++++++++++
 tb/tb_count_down.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the loadable down-counter block: FSM state encoding
// and default counter geometry.
package count_pkg;

  localparam int COUNT_WIDTH = 4;
  localparam int COUNT_MAX   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_dn_core.sv
// Count register with saturating load, decrement and wrap-to-MAX, driven by
// one-hot-ish strobes from the controlling FSM (ld has priority).
module count_dn_core
  import count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter int MAX   = COUNT_MAX
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  input  logic             wrap,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = (ld_val > MAX_V) ? MAX_V : ld_val;
    end else if (wrap) begin
      q_d = MAX_V;
    end else if (dec) begin
      // The FSM only asserts dec when q is nonzero, so this never underflows.
      q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_down.sv
// Loadable down-counter: counts a loaded value to zero, then either wraps to
// MAX (t=1) or stops in DONE until acknowledged (t=0).
module count_down
  import count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter int MAX   = COUNT_MAX
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             t,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t state_q;
  state_t state_d;
  logic   ld;
  logic   dec;
  logic   wrap;

  count_dn_core #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_core (
    .clk    (clk),
    .res    (res),
    .ld     (ld),
    .ld_val (load_val),
    .dec    (dec),
    .wrap   (wrap),
    .q      (Q)
  );

  assign zero = (Q == '0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    dec     = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        ld = load;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pause) begin
          state_d = PAUSE;
        end else if (!zero) begin
          dec = 1'b1;
        end else if (t) begin
          wrap = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      PAUSE: begin
        // A load while paused keeps the FSM paused so the new value is not
        // decremented on the same edge it lands.
        if (load) begin
          ld = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        ld = load;
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are pure decodes of the state register.
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_count_down.sv
// Self-checking bench for count_down: directed scenarios plus randomized
// traffic compared against a behavioural model of the counter.
module tb_count_down;

  localparam int W   = 4;
  localparam int MAX = 10;

  logic         clk = 1'b0;
  logic         res;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         t;
  logic         ack;
  logic [W-1:0] Q;
  logic         zero;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: count value plus "what the counter is doing" flags.
  int m_q;
  bit m_run, m_pause, m_done;

  count_down #(.WIDTH(W), .MAX(MAX)) dut (
    .clk      (clk),
    .res      (res),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .t        (t),
    .ack      (ack),
    .Q        (Q),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void mdl_reset();
    m_q = 0; m_run = 0; m_pause = 0; m_done = 0;
  endfunction

  function automatic void mdl_step();
    int lv;
    lv = (int'(load_val) > MAX) ? MAX : int'(load_val);
    if (res) begin
      mdl_reset();
    end else if (m_run) begin
      if (pause) begin
        m_run = 0; m_pause = 1;
      end else if (m_q > 0) begin
        m_q = m_q - 1;
      end else if (t) begin
        m_q = MAX;
      end else begin
        m_run = 0; m_done = 1;
      end
    end else if (m_pause) begin
      if (load) m_q = lv;
      else if (!pause) begin
        m_pause = 0; m_run = 1;
      end
    end else if (m_done) begin
      if (load) m_q = lv;
      if (ack) m_done = 0;
    end else begin
      if (load) m_q = lv;
      if (start) m_run = 1;
    end
  endfunction

  task automatic check_all();
    chk("Q", Q, m_q);
    chk("zero", zero, (m_q == 0) ? 1 : 0);
    chk("busy", busy, (m_run || m_pause) ? 1 : 0);
    chk("done", done, m_done ? 1 : 0);
  endtask

  task automatic quiet();
    load = 0; start = 0; pause = 0; ack = 0;
  endtask

  // One clock edge: advance the model, then sample 1 time unit after the edge.
  task automatic cycle();
    mdl_step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d ld=%b val=%0d st=%b pa=%b t=%b ack=%b -> Q=%0d z=%b busy=%b done=%b",
             cyc, load, load_val, start, pause, t, ack, Q, zero, busy, done);
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic async_reset(input string tag);
    res = 1;
    #1;
    mdl_reset();
    chk(tag, {busy, done, Q}, 0);
    check_all();
    #2;
    res = 0;
  endtask

  initial begin
    res = 1; quiet(); load_val = '0; t = 0;
    mdl_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    res = 0;
    check_all();

    // Reset mid-RUN.
    load = 1; load_val = 7; cycle();
    quiet(); start = 1; cycle();
    quiet(); repeat (3) cycle();
    chk("run_q_before_reset", Q, 4);
    async_reset("reset_mid_run");

    // One-shot: 5 down to 0, done on the 6th edge after start.
    t = 0; load = 1; load_val = 5; cycle();
    quiet(); start = 1; cycle();
    chk("oneshot_start_q", Q, 5);
    quiet(); repeat (5) cycle();
    chk("oneshot_q0_not_done", done, 0);
    cycle();
    chk("oneshot_done", done, 1);
    repeat (2) cycle();
    chk("oneshot_done_held", done, 1);
    ack = 1; cycle(); quiet();
    chk("oneshot_ack_idle", {busy, done}, 0);

    // Wrap: 2,1,0,10,9,...
    t = 1; load = 1; load_val = 2; cycle();
    quiet(); start = 1; cycle();
    quiet(); repeat (3) cycle();
    chk("wrap_to_max", Q, MAX);
    repeat (6) cycle();
    chk("wrap_busy", busy, 1);
    async_reset("reset_wrap");

    // Saturation, then load+start together.
    t = 0; load = 1; load_val = 15; cycle();
    chk("saturate", Q, MAX);
    load_val = 3; start = 1; cycle();
    quiet();
    chk("load_start_q", Q, 3);
    chk("load_start_busy", busy, 1);
    async_reset("reset_sat");

    // Pause at 4, load 8 while paused, resume.
    load = 1; load_val = 6; cycle();
    quiet(); start = 1; cycle();
    quiet(); repeat (2) cycle();
    pause = 1; repeat (3) cycle();
    chk("pause_hold", Q, 4);
    load = 1; load_val = 8; cycle();
    load = 0; pause = 0; cycle();
    chk("resume_no_dec", Q, 8);
    cycle();
    chk("resume_dec", Q, 7);
    async_reset("reset_pause");

    // Start at zero: done after two edges; start in DONE ignored.
    t = 0; load = 1; load_val = 0; cycle();
    quiet(); start = 1; cycle();
    quiet(); cycle();
    chk("zero_start_done", done, 1);
    start = 1; repeat (2) cycle();
    chk("start_in_done_ignored", done, 1);
    quiet(); ack = 1; cycle(); quiet();

    // Flip t at Q=1: stop at zero with done.
    t = 1; load = 1; load_val = 3; cycle();
    quiet(); start = 1; cycle();
    quiet(); repeat (2) cycle();
    chk("flip_at_one", Q, 1);
    t = 0; repeat (2) cycle();
    chk("flip_done", done, 1);
    ack = 1; cycle(); quiet();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      ack      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) t = ~t;
      if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
